// File: rtl/instr_encoder_if.sv
// Handshake and field bundle between an instruction producer and instr_encoder.
// master drives control bundles and consumes words; slave is the encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic        regDst;
  logic        aluSrc;
  logic        memToReg;
  logic        regWrite;
  logic        memRead;
  logic        memWrite;
  logic        branch;
  logic [1:0]  aluOp;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err;

  modport master (
    output in_valid, regDst, aluSrc, memToReg, regWrite, memRead, memWrite,
           branch, aluOp, rs, rt, rd, shamt, funct, imm, out_ready,
    input  in_ready, out_valid, out_instr, err
  );

  modport slave (
    input  in_valid, regDst, aluSrc, memToReg, regWrite, memRead, memWrite,
           branch, aluOp, rs, rt, rd, shamt, funct, imm, out_ready,
    output in_ready, out_valid, out_instr, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Re-encodes decoded control bundles into 32-bit R/L/S/B words behind a 2-entry FIFO.
// Optional per-class counters and an error counter are enabled by INSTR_ENC_STATS_EN.
module instr_encoder (
  input  logic            clk,
  input  logic            rst,
  instr_encoder_if.slave  bus
`ifdef INSTR_ENC_STATS_EN
  ,
  output logic [15:0]     cnt_r,
  output logic [15:0]     cnt_l,
  output logic [15:0]     cnt_s,
  output logic [15:0]     cnt_b,
  output logic [7:0]      err_cnt
`endif
);

  // {regDst,aluSrc,memToReg,regWrite,memRead,memWrite,branch,aluOp}
  localparam logic [8:0] BUNDLE_R = 9'b1001000_10;
  localparam logic [8:0] BUNDLE_L = 9'b0111100_00;
  localparam logic [8:0] BUNDLE_S = 9'b0100010_00;
  localparam logic [8:0] BUNDLE_B = 9'b0000001_01;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_L,
    CLS_S,
    CLS_B,
    CLS_ILL
  } instrClass_t;

  logic [8:0]  ctrlBundle;
  instrClass_t inClass;
  logic [31:0] encWord;

  logic        inXfer;
  logic        pushEn;
  logic        popEn;
  logic        illegalAcc;

  logic [31:0] fifoMem [2];
  logic        wrPtr;
  logic        rdPtr;
  logic [1:0]  count;
  logic [1:0]  countNext;
  logic        readyQ;
  logic        errQ;
  logic [31:0] lastPopped;

  assign ctrlBundle = {bus.regDst, bus.aluSrc, bus.memToReg, bus.regWrite,
                       bus.memRead, bus.memWrite, bus.branch, bus.aluOp};

  always_comb begin
    inClass = CLS_ILL;
    encWord = '0;
    case (ctrlBundle)
      BUNDLE_R: begin
        inClass = CLS_R;
        encWord = {6'h00, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
      end
      BUNDLE_L: begin
        inClass = CLS_L;
        encWord = {6'h23, bus.rs, bus.rt, bus.imm};
      end
      BUNDLE_S: begin
        inClass = CLS_S;
        encWord = {6'h2B, bus.rs, bus.rt, bus.imm};
      end
      BUNDLE_B: begin
        inClass = CLS_B;
        encWord = {6'h04, bus.rs, bus.rt, bus.imm};
      end
      default: ;
    endcase
  end

  assign inXfer     = bus.in_valid && readyQ;
  assign pushEn     = inXfer && (inClass != CLS_ILL);
  assign illegalAcc = inXfer && (inClass == CLS_ILL);
  assign popEn      = (count != 2'd0) && bus.out_ready;

  always_comb begin
    countNext = count;
    case ({pushEn, popEn})
      2'b10:   countNext = count + 2'd1;
      2'b01:   countNext = count - 2'd1;
      default: countNext = count;
    endcase
  end

  // readyQ is registered from the next count so in_ready never sees out_ready/in_valid
  // combinationally and stays low while rst is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifoMem[0] <= '0;
      fifoMem[1] <= '0;
      wrPtr      <= 1'b0;
      rdPtr      <= 1'b0;
      count      <= 2'd0;
      readyQ     <= 1'b0;
      errQ       <= 1'b0;
      lastPopped <= '0;
    end else begin
      if (pushEn) begin
        fifoMem[wrPtr] <= encWord;
        wrPtr          <= ~wrPtr;
      end
      if (popEn) begin
        lastPopped <= fifoMem[rdPtr];
        rdPtr      <= ~rdPtr;
      end
      count  <= countNext;
      readyQ <= (countNext < 2'd2);
      errQ   <= illegalAcc;
    end
  end

  assign bus.in_ready  = readyQ;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_instr = (count != 2'd0) ? fifoMem[rdPtr] : lastPopped;
  assign bus.err       = errQ;

`ifdef INSTR_ENC_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= '0;
      cnt_l   <= '0;
      cnt_s   <= '0;
      cnt_b   <= '0;
      err_cnt <= '0;
    end else begin
      if (pushEn) begin
        case (inClass)
          CLS_R:   cnt_r <= cnt_r + 16'd1;
          CLS_L:   cnt_l <= cnt_l + 16'd1;
          CLS_S:   cnt_s <= cnt_s + 16'd1;
          CLS_B:   cnt_b <= cnt_b + 16'd1;
          default: ;
        endcase
      end
      if (illegalAcc && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule
